// File: rtl/snn_ff_pkg.sv
// Shared types and helpers for the SNN feed-forward spike readers.
package snn_ff_pkg;

   // Ceiling log2, never below 1 so derived widths stay legal.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

   // Default array geometry.
   localparam int DEF_TIME_STEP = 8;
   localparam int DEF_N_PRE     = 256;
   localparam int DEF_ADDR_W    = clog2(DEF_N_PRE);
   localparam int DEF_CNT_W     = clog2(DEF_TIME_STEP + 1);
   localparam int DEF_TS_W      = clog2(DEF_TIME_STEP);

   // Decoded per-neuron record at the default geometry; readers built with
   // other widths declare a local struct of the same shape.
   typedef struct packed {
      logic [DEF_ADDR_W-1:0]    addr;
      logic [DEF_TIME_STEP-1:0] bits;
      logic [DEF_CNT_W-1:0]     cnt;
      logic [DEF_TS_W-1:0]      first_ts;
      logic [DEF_TS_W-1:0]      last_ts;
      logic                     any;
   } spike_rec_t;

   // Sweep controller states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } rd_state_e;

endpackage

// File: rtl/spike_bitmap_decoder.sv
// Combinational decode of a one-bit-per-time-step spike bitmap into count,
// first/last spiking step and an any-spike flag. Shared by pre/post readers.
module spike_bitmap_decoder
   import snn_ff_pkg::*;
#(
   parameter int TIME_STEP = 8,
   parameter int CNT_W     = clog2(TIME_STEP + 1),
   parameter int TS_W      = clog2(TIME_STEP)
) (
   input  logic [TIME_STEP-1:0] i_bits,
   output logic [CNT_W-1:0]     o_cnt,
   output logic [TS_W-1:0]      o_first_ts,
   output logic [TS_W-1:0]      o_last_ts,
   output logic                 o_any
);

   assign o_any = |i_bits;

   // Popcount plus low/high priority encodes; both indices read 0 for an empty map.
   always_comb begin
      o_cnt      = '0;
      o_first_ts = '0;
      o_last_ts  = '0;
      for (int i = TIME_STEP - 1; i >= 0; i--) begin
         if (i_bits[i]) o_first_ts = TS_W'(i);
      end
      for (int i = 0; i < TIME_STEP; i++) begin
         if (i_bits[i]) begin
            o_cnt     = o_cnt + CNT_W'(1);
            o_last_ts = TS_W'(i);
         end
      end
   end

endmodule

// File: rtl/pre_spike_reader.sv
// Sweeps the pre-synaptic spike-history SRAM after a reference window and
// streams one decoded record per neuron to the weight-update engine.
module pre_spike_reader
   import snn_ff_pkg::*;
#(
   parameter int PRE_NEUR_SPIKE_CNT_WIDTH = 8,
   parameter int TIME_STEP = 8,
   parameter int N_PRE     = 256,
   parameter int ADDR_W    = clog2(N_PRE),
   parameter int CNT_W     = clog2(TIME_STEP + 1),
   parameter int TS_W      = clog2(TIME_STEP)
) (
   input  logic                                CLK,
   input  logic                                RST,
   input  logic                                start,
   output logic                                busy,
   output logic                                done,
   output logic                                sram_rd_en,
   output logic [ADDR_W-1:0]                   sram_addr,
   input  logic [PRE_NEUR_SPIKE_CNT_WIDTH-1:0] sram_rdata,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [ADDR_W-1:0]                   out_addr,
   output logic [TIME_STEP-1:0]                out_bits,
   output logic [CNT_W-1:0]                    out_cnt,
   output logic [TS_W-1:0]                     out_first_ts,
   output logic [TS_W-1:0]                     out_last_ts,
   output logic                                out_any
);

   if (PRE_NEUR_SPIKE_CNT_WIDTH < TIME_STEP) begin : g_width_chk
      $error("pre_spike_reader: SRAM word narrower than TIME_STEP");
   end

   typedef struct packed {
      logic [ADDR_W-1:0]    addr;
      logic [TIME_STEP-1:0] bits;
      logic [CNT_W-1:0]     cnt;
      logic [TS_W-1:0]      first_ts;
      logic [TS_W-1:0]      last_ts;
      logic                 any;
   } rec_t;

   rd_state_e            r_state;
   logic [ADDR_W-1:0]    r_rd_ptr;
   logic [ADDR_W-1:0]    r_land_addr;
   logic                 r_inflight;
   logic                 r_busy;
   logic                 r_done;

   rec_t                 r_fifo [2];
   logic                 r_wr_sel;
   logic                 r_rd_sel;
   logic [1:0]           r_count;

   logic [TIME_STEP-1:0] w_bits;
   logic [CNT_W-1:0]     w_cnt;
   logic [TS_W-1:0]      w_first_ts;
   logic [TS_W-1:0]      w_last_ts;
   logic                 w_any;
   rec_t                 w_push_rec;
   rec_t                 w_head;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_issue;
   logic [1:0]           w_occ;
   logic [1:0]           w_count_next;

   // Upper SRAM bits carry nothing for this window length.
   if (PRE_NEUR_SPIKE_CNT_WIDTH > TIME_STEP) begin : g_hi
      logic w_unused_hi;
      assign w_unused_hi = ^sram_rdata[PRE_NEUR_SPIKE_CNT_WIDTH-1:TIME_STEP];
   end

   // Return path: read data lands the cycle after the strobe.
   assign w_bits = sram_rdata[TIME_STEP-1:0];
   assign w_push = r_inflight;

   spike_bitmap_decoder #(
      .TIME_STEP (TIME_STEP),
      .CNT_W     (CNT_W),
      .TS_W      (TS_W)
   ) u_dec (
      .i_bits     (w_bits),
      .o_cnt      (w_cnt),
      .o_first_ts (w_first_ts),
      .o_last_ts  (w_last_ts),
      .o_any      (w_any)
   );

   assign w_push_rec = '{addr: r_land_addr, bits: w_bits, cnt: w_cnt,
                         first_ts: w_first_ts, last_ts: w_last_ts, any: w_any};

   // Output handshake. Occupancy for the issue decision counts the slot freed
   // by this cycle's pop, which is what lets the stream sustain one record per
   // cycle while never holding more than two results (FIFO + landing read).
   assign out_valid    = (r_count != 2'd0);
   assign w_pop        = out_valid & out_ready;
   assign w_occ        = r_count - {1'b0, w_pop} + {1'b0, r_inflight};
   assign w_issue      = (r_state == ST_SCAN) && (w_occ < 2'd2);
   assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

   assign sram_rd_en = w_issue;
   assign sram_addr  = r_rd_ptr;
   assign busy       = r_busy;
   assign done       = r_done;

   // Data fields read as zero whenever no record is presented.
   assign w_head       = out_valid ? r_fifo[r_rd_sel] : '0;
   assign out_addr     = w_head.addr;
   assign out_bits     = w_head.bits;
   assign out_cnt      = w_head.cnt;
   assign out_first_ts = w_head.first_ts;
   assign out_last_ts  = w_head.last_ts;
   assign out_any      = w_head.any;

   // Sweep controller: address walk, in-flight tracking, busy/done.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= ST_IDLE;
         r_rd_ptr    <= '0;
         r_land_addr <= '0;
         r_inflight  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         r_done     <= 1'b0;
         if (w_issue) r_land_addr <= r_rd_ptr;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state  <= ST_SCAN;
                  r_rd_ptr <= '0;
                  r_busy   <= 1'b1;
               end
            end
            ST_SCAN: begin
               if (w_issue) begin
                  if (r_rd_ptr == ADDR_W'(N_PRE - 1)) r_state  <= ST_DRAIN;
                  else                                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
               end
            end
            ST_DRAIN: begin
               // No reads issue here, so an empty next FIFO means the last
               // record has just been handed over.
               if (w_count_next == 2'd0) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Two-entry record FIFO pointers and occupancy.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_count  <= 2'd0;
         r_wr_sel <= 1'b0;
         r_rd_sel <= 1'b0;
      end else begin
         if (w_push) r_wr_sel <= ~r_wr_sel;
         if (w_pop)  r_rd_sel <= ~r_rd_sel;
         r_count <= w_count_next;
      end
   end

   // FIFO storage; contents are qualified by the occupancy count.
   always_ff @(posedge CLK) begin
      if (w_push) r_fifo[r_wr_sel] <= w_push_rec;
   end

endmodule
